// File: rtl/butterfly_addr_gen_pkg.sv
// rtl/butterfly_addr_gen_pkg.sv - shared types, drain default and operand index helper for butterfly_addr_gen
`ifndef DELAY_FLP_ADDER
`define DELAY_FLP_ADDER 5
`endif
`ifndef DELAY_COMPLEX_MULT
`define DELAY_COMPLEX_MULT 6
`endif

package butterfly_addr_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bfg_state_t;

    localparam int DEFAULT_DRAIN_CYCLES = `DELAY_FLP_ADDER + `DELAY_COMPLEX_MULT + 4;
    localparam int MAX_ADDR_WIDTH       = 30;

    // Lower operand index: cnt with a zero spliced in at bit k.
    function automatic logic [MAX_ADDR_WIDTH:0] insert_zero_bit(
        input logic [MAX_ADDR_WIDTH-1:0] cnt,
        input logic [4:0]                k
    );
        logic [MAX_ADDR_WIDTH:0] wide;
        logic [MAX_ADDR_WIDTH:0] low_mask;
        wide     = {1'b0, cnt};
        low_mask = ({{MAX_ADDR_WIDTH{1'b0}}, 1'b1} << k) - 1'b1;
        return ((wide & ~low_mask) << 1) | (wide & low_mask);
    endfunction

endpackage

// File: rtl/butterfly_addr_gen_drain_counter.sv
// rtl/butterfly_addr_gen_drain_counter.sv - loadable down-counter timing the pipeline drain
module bfg_drain_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/butterfly_addr_gen.sv
// rtl/butterfly_addr_gen.sv - stage/butterfly sequencer for the shared FFT/NTT butterfly datapath
module butterfly_addr_gen
    import butterfly_addr_gen_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  is_dif,
    input  logic                  en,
    output logic [ADDR_WIDTH:0]   base_address,
    output logic [ADDR_WIDTH:0]   gap,
    output logic [ADDR_WIDTH-1:0] tw_index,
    output logic                  bf_valid,
    output logic                  ctrl_stall,
    output logic                  ctrl_done,
    output logic                  busy
);

    localparam int               LOG_N    = ADDR_WIDTH + 1;
    localparam int               DRAIN_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [4:0]       K_LAST   = 5'(LOG_N - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    bfg_state_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [4:0]              k_q, k_d;
    logic                    dif_q, dif_d;
    logic [ADDR_WIDTH:0]     base_q, base_d;
    logic [ADDR_WIDTH:0]     gap_q, gap_d;
    logic [ADDR_WIDTH-1:0]   tw_q, tw_d;
    logic                    valid_q, valid_d;
    logic                    stall_q, stall_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;

    logic                    drain_load;
    logic                    drain_dec;
    logic                    drain_zero;
    logic [ADDR_WIDTH-1:0]   tw_low;

    bfg_drain_counter #(
        .WIDTH(DRAIN_W)
    ) u_drain (
        .clk       (clk),
        .rst       (rst),
        .load      (drain_load),
        .load_value(DRAIN_LOAD),
        .en        (drain_dec),
        .zero      (drain_zero)
    );

    // Twiddle index is the low k bits of cnt, left-justified in the ROM index.
    assign tw_low = cnt_q & ~({ADDR_WIDTH{1'b1}} << k_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        dif_d      = dif_q;
        base_d     = base_q;
        gap_d      = gap_q;
        tw_d       = tw_q;
        valid_d    = 1'b0;
        stall_d    = stall_q;
        done_d     = 1'b0;
        drain_load = 1'b0;
        drain_dec  = 1'b0;

        if (en) begin
            stall_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        k_d     = is_dif ? K_LAST : 5'd0;
                        dif_d   = is_dif;
                    end
                end
                RUN: begin
                    valid_d = 1'b1;
                    base_d  = (ADDR_WIDTH + 1)'(insert_zero_bit(MAX_ADDR_WIDTH'(cnt_q), k_q));
                    gap_d   = {{ADDR_WIDTH{1'b0}}, 1'b1} << k_q;
                    tw_d    = tw_low << (5'(ADDR_WIDTH) - k_q);
                    if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                        state_d    = DRAIN;
                        drain_load = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    stall_d = 1'b1;
                    if (!drain_zero) begin
                        drain_dec = 1'b1;
                    end else if (k_q == (dif_q ? 5'd0 : K_LAST)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        cnt_d   = '0;
                        k_d     = dif_q ? (k_q - 5'd1) : (k_q + 5'd1);
                    end
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // busy stays up through the ctrl_done cycle and drops after it.
        busy_d = (state_d != IDLE) || done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            dif_q   <= 1'b0;
            base_q  <= '0;
            gap_q   <= '0;
            tw_q    <= '0;
            valid_q <= 1'b0;
            stall_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            dif_q   <= dif_d;
            base_q  <= base_d;
            gap_q   <= gap_d;
            tw_q    <= tw_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign base_address = base_q;
    assign gap          = gap_q;
    assign tw_index     = tw_q;
    assign bf_valid     = valid_q;
    assign ctrl_stall   = stall_q;
    assign ctrl_done    = done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_butterfly_addr_gen.sv
// tb/tb_butterfly_addr_gen.sv - self-checking bench for butterfly_addr_gen (small and default sizes)
module tb_butterfly_addr_gen;

    localparam int S_AW = 3;
    localparam int S_N  = 16;
    localparam int S_D  = 3;
    localparam int L_AW = 12;
    localparam int L_N  = 8192;
    localparam int L_D  = butterfly_addr_gen_pkg::DEFAULT_DRAIN_CYCLES;

    typedef struct {
        int base;
        int gap;
        int tw;
    } bf_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic            s_start = 1'b0, s_is_dif = 1'b0, s_en = 1'b0;
    logic [S_AW:0]   s_base, s_gap;
    logic [S_AW-1:0] s_tw;
    logic            s_valid, s_stall, s_done, s_busy;

    logic            l_start = 1'b0, l_is_dif = 1'b0, l_en = 1'b0;
    logic [L_AW:0]   l_base, l_gap;
    logic [L_AW-1:0] l_tw;
    logic            l_valid, l_stall, l_done, l_busy;

    int checks = 0;
    int errors = 0;

    bf_t exp_q[$];
    int  obs_base[64];
    int  obs_gap[64];
    int  obs_tw[64];
    int  nvalid, nstall, ndone;
    bit  exp_busy;
    int  hits[L_N];

    always #5 clk = ~clk;

    butterfly_addr_gen #(.ADDR_WIDTH(S_AW), .DRAIN_CYCLES(S_D)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .is_dif(s_is_dif), .en(s_en),
        .base_address(s_base), .gap(s_gap), .tw_index(s_tw),
        .bf_valid(s_valid), .ctrl_stall(s_stall), .ctrl_done(s_done), .busy(s_busy)
    );

    butterfly_addr_gen #(.ADDR_WIDTH(L_AW)) u_large (
        .clk(clk), .rst(rst), .start(l_start), .is_dif(l_is_dif), .en(l_en),
        .base_address(l_base), .gap(l_gap), .tw_index(l_tw),
        .bf_valid(l_valid), .ctrl_stall(l_stall), .ctrl_done(l_done), .busy(l_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Butterflies listed as groups of 2*gap points, j-th pair inside a group.
    task automatic build_model(input bit dif, input int aw);
        int n;
        int g_len;
        n = 1 << (aw + 1);
        exp_q.delete();
        for (int s = 0; s < aw + 1; s++) begin
            g_len = dif ? (n >> (s + 1)) : (1 << s);
            for (int g = 0; g < n / (2 * g_len); g++) begin
                for (int j = 0; j < g_len; j++) begin
                    exp_q.push_back('{base: g * 2 * g_len + j, gap: g_len, tw: j * (n / (2 * g_len))});
                end
            end
        end
    endtask

    task automatic s_tick();
        bf_t e;
        int  p_base, p_gap, p_tw, p_stall;
        p_base  = 32'(s_base);
        p_gap   = 32'(s_gap);
        p_tw    = 32'(s_tw);
        p_stall = 32'(s_stall);
        @(posedge clk);
        @(negedge clk);
        if (!s_en) begin
            chk("hold_valid", 32'(s_valid), 32'd0);
            chk("hold_base", 32'(s_base), p_base);
            chk("hold_gap", 32'(s_gap), p_gap);
            chk("hold_tw", 32'(s_tw), p_tw);
            chk("hold_stall", 32'(s_stall), p_stall);
        end
        if (s_valid) begin
            chk("stall_overlap", 32'(s_stall), 32'd0);
            if (exp_q.size() == 0) begin
                chk("extra_valid", 32'(s_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("base", 32'(s_base), e.base);
                chk("gap", 32'(s_gap), e.gap);
                chk("tw_index", 32'(s_tw), e.tw);
            end
            if (nvalid < 64) begin
                obs_base[nvalid] = 32'(s_base);
                obs_gap[nvalid]  = 32'(s_gap);
                obs_tw[nvalid]   = 32'(s_tw);
            end
            nvalid++;
        end
        if (s_stall && s_en) nstall++;
        if (s_done) ndone++;
        chk("busy", 32'(s_busy), 32'(exp_busy));
        if (s_done) exp_busy = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_base"}, 32'(s_base), 32'd0);
        chk({tag, "_gap"}, 32'(s_gap), 32'd0);
        chk({tag, "_tw"}, 32'(s_tw), 32'd0);
        chk({tag, "_valid"}, 32'(s_valid), 32'd0);
        chk({tag, "_stall"}, 32'(s_stall), 32'd0);
        chk({tag, "_done"}, 32'(s_done), 32'd0);
        chk({tag, "_busy"}, 32'(s_busy), 32'd0);
    endtask

    task automatic run_small(input bit dif, input bit pause_run, input bit pause_drain,
                             input bit mid_start, input bit mid_rst);
        int  pause_left;
        bit  pr_fired, pd_fired, ms_fired, aborted;
        build_model(dif, S_AW);
        nvalid = 0; nstall = 0; ndone = 0;
        pause_left = 0; pr_fired = 0; pd_fired = 0; ms_fired = 0; aborted = 0;
        s_is_dif = dif;
        s_en     = 1'b1;
        s_start  = 1'b1;
        exp_busy = 1'b1;
        s_tick();
        s_start  = 1'b0;
        s_is_dif = ~dif;
        for (int c = 0; c < 400 && ndone == 0 && !aborted; c++) begin
            s_en    = 1'b1;
            s_start = 1'b0;
            if (pause_left > 0) begin
                s_en = 1'b0;
                pause_left--;
            end else if (pause_run && !pr_fired && nvalid == 5) begin
                s_en = 1'b0; pause_left = 4; pr_fired = 1;
            end else if (pause_drain && !pd_fired && nstall == 1) begin
                s_en = 1'b0; pause_left = 4; pd_fired = 1;
            end else if (mid_start && !ms_fired && nvalid == 10) begin
                s_start = 1'b1; ms_fired = 1;
            end else if (mid_rst && nvalid == 19) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                exp_busy = 1'b0;
                check_reset_outputs("mid_rst");
                s_tick();
                chk("post_rst_done", 32'(ndone), 32'd0);
                aborted = 1;
            end
            if (!aborted) s_tick();
        end
        s_start = 1'b0;
        s_en    = 1'b1;
        if (!aborted) begin
            chk("done_count", 32'(ndone), 32'd1);
            chk("valid_total", 32'(nvalid), 32'(4 * (S_N / 2)));
            chk("stall_total", 32'(nstall), 32'(4 * S_D));
            chk("model_left", 32'(exp_q.size()), 32'd0);
            s_tick();
            chk("done_once", 32'(s_done), 32'd0);
            chk("busy_drop", 32'(s_busy), 32'd0);
        end
    endtask

    initial begin
        int lvalid, lstall, ldone, bad, overlap, gap_err, stage, idx;

        rst = 1'b1;
        s_start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        s_start = 1'b0;
        check_reset_outputs("reset");
        rst = 1'b0;
        exp_busy = 1'b0;
        s_en = 1'b1;
        s_tick();
        chk("idle_no_valid", 32'(s_valid), 32'd0);

        run_small(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("dit_s0_base", 32'(obs_base[i]), 32'(2 * i));
            chk("dit_s0_gap", 32'(obs_gap[i]), 32'd1);
            chk("dit_s0_tw", 32'(obs_tw[i]), 32'd0);
            chk("dit_s3_base", 32'(obs_base[24 + i]), 32'(i));
            chk("dit_s3_gap", 32'(obs_gap[24 + i]), 32'd8);
            chk("dit_s3_tw", 32'(obs_tw[24 + i]), 32'(i));
        end

        run_small(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("dif_first_base", 32'(obs_base[0]), 32'd0);
        chk("dif_first_gap", 32'(obs_gap[0]), 32'd8);
        chk("dif_last_base", 32'(obs_base[31]), 32'd14);
        chk("dif_last_gap", 32'(obs_gap[31]), 32'd1);
        for (int s = 0; s < 4; s++) chk("dif_gap_seq", 32'(obs_gap[8 * s]), 32'(8 >> s));
        for (int i = 0; i < 8; i++) chk("dif_gap2_tw", 32'(obs_tw[16 + i]), 32'((i % 2) * 4));

        run_small(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_small(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        run_small(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_small(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Default-size DIT transform under random back-pressure.
        foreach (hits[i]) hits[i] = 0;
        lvalid = 0; lstall = 0; ldone = 0; overlap = 0; gap_err = 0;
        l_is_dif = 1'b0;
        l_en     = 1'b1;
        l_start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        l_start = 1'b0;
        chk("large_busy", 32'(l_busy), 32'd1);
        for (int c = 0; c < 90000 && ldone == 0; c++) begin
            l_en = ($urandom_range(15, 0) != 0);
            @(posedge clk);
            @(negedge clk);
            if (l_valid) begin
                if (l_stall) overlap++;
                stage = lvalid >> L_AW;
                if (32'(l_gap) != (32'd1 << stage)) gap_err++;
                idx = 32'(l_base);
                if (idx < L_N) hits[idx]++; else gap_err++;
                idx = 32'(l_base) + 32'(l_gap);
                if (idx < L_N) hits[idx]++; else gap_err++;
                lvalid++;
                if ((lvalid % (L_N / 2)) == 0) begin
                    bad = 0;
                    foreach (hits[i]) begin
                        if (hits[i] != 1) bad++;
                        hits[i] = 0;
                    end
                    chk("large_stage_cover", 32'(bad), 32'd0);
                end
            end
            if (l_stall && l_en) lstall++;
            if (l_done) ldone++;
        end
        chk("large_done", 32'(ldone), 32'd1);
        chk("large_overlap", 32'(overlap), 32'd0);
        chk("large_gap_err", 32'(gap_err), 32'd0);
        chk("large_valid_total", 32'(lvalid), 32'((L_AW + 1) * (L_N / 2)));
        chk("large_stall_total", 32'(lstall), 32'((L_AW + 1) * L_D));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
